mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-ported byte-addressed main memory between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request at a time, sequences it onto the memory request lines, waits for completion and routes the response back to the owner. It sits between the core front/back ends and the memory model.

## Interface
- XLEN, 32: address/data width
- TIMEOUT, 15: max cycles in WAIT before error (only with timeout feature)
- clk  in  1  core clock, all logic on rising edge
- rst_n  in  1  reset rst_n, synchronous, active-low
- ifu_req_v  in  1  IFU read request valid
- ifu_adr  in  XLEN  IFU byte address
- ifu_gnt  out  1  IFU request accepted this cycle
- ifu_resp_v  out  1  IFU response valid (1-cycle pulse)
- ifu_resp  out  XLEN  IFU read data
- ifu_err  out  1  IFU timeout error, qualified by ifu_resp_v
- lsu_req_v  in  1  LSU request valid
- lsu_we  in  1  1 = write, 0 = read
- lsu_adr  in  XLEN  LSU byte address
- lsu_data  in  XLEN  LSU write data
- lsu_strobe  in  4  LSU byte enables
- lsu_gnt, lsu_resp_v, lsu_resp, lsu_err  out  1/1/XLEN/1  as IFU equivalents
- mem_r_v, mem_w_v  out  1  memory read/write strobe
- mem_adr, mem_data  out  XLEN  memory address / write data
- mem_strobe  out  4  memory byte enables
- mem_resp  in  XLEN  memory read data
- mem_ack  in  1  memory read completion

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_v, assert winner's gnt (combinational from req_v and priority), latch adr/we/data/strobe and owner id; go ISSUE. Request accepted iff req_v && gnt in same cycle. Requester holds req_v until gnt.
- Priority: round-robin on last owner. Both requesting: the one that did not own the previous transaction wins; after reset, LSU wins first tie. Single requester always wins.
- ISSUE: drive mem_r_v (read) or mem_w_v (write) high exactly one cycle with latched adr/data/strobe (strobe forced 4'b1111 for IFU). Write → RESP; read → WAIT.
- WAIT: mem_r_v/mem_w_v low, mem_adr held. On mem_ack=1 capture mem_resp into response register, go RESP. mem_ack ignored in all other states.
- RESP: owner's resp_v=1 for one cycle with registered data (writes: resp=0, resp_v acts as write-done); go IDLE. No gnt in RESP; next grant earliest in following IDLE cycle.
- Non-owner resp_v, err always 0.
- Reset (any state, incl. mid-transaction): state IDLE, in-flight request dropped without response, last-owner = IFU (so LSU wins first tie); all outputs 0 (gnt, resp_v, resp, err, mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe).

## Timing
- Cycle 0 accept (IDLE, gnt), cycle 1 ISSUE, read: ack in cycle N≥2 → resp_v in cycle N+1. Minimum read latency 3 cycles accept-to-resp_v.
- Write: resp_v at cycle 2; throughput one write per 3 cycles.
- Back-to-back: new gnt earliest cycle after RESP.
- ack arriving in the ISSUE cycle is ignored; memory must deliver ack no earlier than the cycle after mem_r_v.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: WAIT counter (width clog2(TIMEOUT+1)) cleared on entering WAIT, increments each WAIT cycle without ack; when it equals TIMEOUT and no ack → RESP with err=1, resp=0. Ack in the same cycle as the limit wins (no error).
- Undefined: no counter, WAIT holds indefinitely, ifu_err/lsu_err tied 0.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), owner enum (OWN_IFU, OWN_LSU), default TIMEOUT constant.
- Sub-module rr_arb2: 2-input round-robin picker with last-owner register, updated only on accept.

## Test plan
- Single IFU read adr 0x100, ack 2 cycles after mem_r_v, mem_resp 0xDEADBEEF -> ifu_resp_v pulse with 0xDEADBEEF, mem_strobe 4'hF, lsu_resp_v never high.
- LSU write adr 0x200 data 0x11223344 strobe 4'b0011 -> mem_w_v one cycle with those values, lsu_resp_v at accept+2, no ack needed.
- IFU and LSU held requesting simultaneously from reset, 4 transactions -> grants LSU, IFU, LSU, IFU; each response to correct owner.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=15, no ack -> resp_v with err=1, resp=0 exactly 16 cycles after ISSUE; ack on cycle 15 of WAIT -> err=0.
- rst_n low during WAIT -> next cycle all outputs 0, state IDLE, later ack ignored, no resp_v; next request served normally.
- Stale mem_ack high during IDLE/ISSUE -> no state change, no response.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; remembers the owner of the last accepted request.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   req_ifu,
    input  logic   req_lsu,
    input  logic   accept,
    output logic   gnt_ifu,
    output logic   gnt_lsu,
    output owner_t winner
);

    owner_t last_r;
    owner_t win_s;

    // On a tie the requester that did not own the previous transaction wins
    always_comb begin
        win_s = OWN_LSU;
        if (req_ifu && req_lsu) begin
            win_s = (last_r == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (req_ifu) begin
            win_s = OWN_IFU;
        end else begin
            win_s = OWN_LSU;
        end
    end

    assign gnt_ifu = en && req_ifu && (win_s == OWN_IFU);
    assign gnt_lsu = en && req_lsu && (win_s == OWN_LSU);
    assign winner  = win_s;

    // Last-owner register, IFU after reset so the LSU takes the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= OWN_IFU;
        end else if (accept) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter for the single-ported main memory.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_req_v,
    input  logic [XLEN-1:0] ifu_adr,
    output logic            ifu_gnt,
    output logic            ifu_resp_v,
    output logic [XLEN-1:0] ifu_resp,
    output logic            ifu_err,
    input  logic            lsu_req_v,
    input  logic            lsu_we,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [3:0]      lsu_strobe,
    output logic            lsu_gnt,
    output logic            lsu_resp_v,
    output logic [XLEN-1:0] lsu_resp,
    output logic            lsu_err,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [XLEN-1:0] mem_resp,
    input  logic            mem_ack
);

    state_t          state_r;
    state_t          state_nxt_s;
    owner_t          owner_r;
    owner_t          win_s;
    logic            we_r;
    logic            en_s;
    logic            accept_s;
    logic            we_nxt_s;
    logic            to_resp_s;
    logic            timeout_s;
    logic            err_s;
    logic [XLEN-1:0] rdata_s;

    // Grants are suppressed while reset is held so every output reads 0
    assign en_s     = rst_n && (state_r == IDLE);
    assign accept_s = en_s && (ifu_req_v || lsu_req_v);
    assign we_nxt_s = (win_s == OWN_LSU) && lsu_we;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_s),
        .req_ifu (ifu_req_v),
        .req_lsu (lsu_req_v),
        .accept  (accept_s),
        .gnt_ifu (ifu_gnt),
        .gnt_lsu (lsu_gnt),
        .winner  (win_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;

    // Fires in the WAIT cycle whose increment would reach TIMEOUT, giving TIMEOUT WAIT cycles
    assign cnt_inc_s = wait_cnt_r + CNT_W'(1);
    assign timeout_s = (state_r == WAIT) && (cnt_inc_s == CNT_W'(TIMEOUT));

    // WAIT cycle counter, held at zero outside WAIT
    always_ff @(posedge clk) begin
        if (!rst_n || (state_r != WAIT)) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_ack) begin
            wait_cnt_r <= cnt_inc_s;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT != 0);
    assign timeout_s        = 1'b0;
`endif

    // Next-state logic and the data/error routed into RESP
    always_comb begin
        state_nxt_s = state_r;
        rdata_s     = {XLEN{1'b0}};
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = we_r ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    state_nxt_s = RESP;
                    rdata_s     = mem_resp;
                end else if (timeout_s) begin
                    state_nxt_s = RESP;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign to_resp_s = (state_nxt_s == RESP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch; mem_adr/data/strobe keep the accepted request until the next one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r    <= OWN_IFU;
            we_r       <= 1'b0;
            mem_adr    <= {XLEN{1'b0}};
            mem_data   <= {XLEN{1'b0}};
            mem_strobe <= 4'b0000;
        end else if (accept_s && (win_s == OWN_LSU)) begin
            owner_r    <= OWN_LSU;
            we_r       <= we_nxt_s;
            mem_adr    <= lsu_adr;
            mem_data   <= lsu_data;
            mem_strobe <= lsu_strobe;
        end else if (accept_s) begin
            owner_r    <= OWN_IFU;
            we_r       <= 1'b0;
            mem_adr    <= ifu_adr;
            mem_data   <= {XLEN{1'b0}};
            mem_strobe <= 4'b1111;
        end else begin
            owner_r    <= owner_r;
            we_r       <= we_r;
            mem_adr    <= mem_adr;
            mem_data   <= mem_data;
            mem_strobe <= mem_strobe;
        end
    end

    // One-cycle memory strobes, raised for the ISSUE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r_v <= 1'b0;
            mem_w_v <= 1'b0;
        end else begin
            mem_r_v <= accept_s && !we_nxt_s;
            mem_w_v <= accept_s && we_nxt_s;
        end
    end

    // Response registers: only the owner sees resp_v/resp/err, and only in RESP
    always_ff @(posedge clk) begin
        if (!rst_n || !to_resp_s) begin
            ifu_resp_v <= 1'b0;
            ifu_resp   <= {XLEN{1'b0}};
            ifu_err    <= 1'b0;
            lsu_resp_v <= 1'b0;
            lsu_resp   <= {XLEN{1'b0}};
            lsu_err    <= 1'b0;
        end else if (owner_r == OWN_LSU) begin
            ifu_resp_v <= 1'b0;
            ifu_resp   <= {XLEN{1'b0}};
            ifu_err    <= 1'b0;
            lsu_resp_v <= 1'b1;
            lsu_resp   <= rdata_s;
            lsu_err    <= err_s;
        end else begin
            ifu_resp_v <= 1'b1;
            ifu_resp   <= rdata_s;
            ifu_err    <= err_s;
            lsu_resp_v <= 1'b0;
            lsu_resp   <= {XLEN{1'b0}};
            lsu_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected responses,
// a negedge monitor pops and compares them whenever a resp_v is seen.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_v;
    logic [31:0] ifu_adr;
    logic        ifu_gnt, ifu_resp_v, ifu_err;
    logic [31:0] ifu_resp;
    logic        lsu_req_v, lsu_we;
    logic [31:0] lsu_adr, lsu_data;
    logic [3:0]  lsu_strobe;
    logic        lsu_gnt, lsu_resp_v, lsu_err;
    logic [31:0] lsu_resp;
    logic        mem_r_v, mem_w_v;
    logic [31:0] mem_adr, mem_data;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_resp;
    logic        mem_ack;

    typedef struct {
        bit          own;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   auto_ack = 1'b0;
    logic pend = 1'b0;
    logic [31:0] auto_data = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_v(ifu_req_v), .ifu_adr(ifu_adr), .ifu_gnt(ifu_gnt),
        .ifu_resp_v(ifu_resp_v), .ifu_resp(ifu_resp), .ifu_err(ifu_err),
        .lsu_req_v(lsu_req_v), .lsu_we(lsu_we), .lsu_adr(lsu_adr), .lsu_data(lsu_data),
        .lsu_strobe(lsu_strobe), .lsu_gnt(lsu_gnt), .lsu_resp_v(lsu_resp_v),
        .lsu_resp(lsu_resp), .lsu_err(lsu_err),
        .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
        .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_ack(mem_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change #1 after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            mem_ack  = pend;
            mem_resp = auto_data;
            pend     = mem_r_v;
        end else begin
            pend = 1'b0;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {20'h0, ifu_gnt, ifu_resp_v, ifu_err, lsu_gnt, lsu_resp_v, lsu_err,
                             mem_r_v, mem_w_v, mem_strobe}, 32'h0);
        chk({name, "_ifu_resp"}, ifu_resp, 32'h0);
        chk({name, "_lsu_resp"}, lsu_resp, 32'h0);
        chk({name, "_mem_adr"}, mem_adr, 32'h0);
        chk({name, "_mem_data"}, mem_data, 32'h0);
    endtask

    // IFU read, ack placed in WAIT cycle ack_dly (1 = first WAIT cycle)
    task automatic ifu_read(input string name, input logic [31:0] adr, input logic [31:0] data,
                            input int ack_dly, input bit stale_issue);
        ifu_req_v = 1'b1;
        ifu_adr   = adr;
        #1;
        chk({name, "_gnt"}, {30'h0, ifu_gnt, lsu_gnt}, 32'h2);
        sb_q.push_back('{1'b0, data, 1'b0});
        step();
        ifu_req_v = 1'b0;
        chk({name, "_issue"}, {28'h0, mem_r_v, mem_w_v, 2'b00}, 32'h8);
        chk({name, "_adr"}, mem_adr, adr);
        chk({name, "_strobe"}, {28'h0, mem_strobe}, 32'hF);
        if (stale_issue) begin
            mem_ack  = 1'b1;
            mem_resp = 32'hBAD0BAD0;
        end
        for (int i = 0; i < ack_dly; i++) begin
            step();
            mem_ack = 1'b0;
        end
        chk({name, "_wait_rv"}, {31'h0, mem_r_v}, 32'h0);
        mem_ack  = 1'b1;
        mem_resp = data;
        step();
        mem_ack  = 1'b0;
        mem_resp = 32'h0;
        chk({name, "_resp_v"}, {30'h0, ifu_resp_v, lsu_resp_v}, 32'h2);
        step();
    endtask

    // Scoreboard monitor
    initial begin
        exp_t        e;
        bit          own;
        logic [31:0] dat;
        logic        er;
        logic        other_er;
        forever begin
            @(negedge clk);
            if (ifu_resp_v || lsu_resp_v) begin
                checks++;
                if (ifu_resp_v && lsu_resp_v) begin
                    errors++;
                    $display("FAIL sb_both_resp: got ifu_resp_v=1 lsu_resp_v=1 expected one");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got resp ifu=%b lsu=%b expected none",
                             ifu_resp_v, lsu_resp_v);
                end else begin
                    e        = sb_q.pop_front();
                    own      = lsu_resp_v;
                    dat      = own ? lsu_resp : ifu_resp;
                    er       = own ? lsu_err : ifu_err;
                    other_er = own ? ifu_err : lsu_err;
                    if (own !== e.own || dat !== e.data || er !== e.err || other_er !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_resp: got own=%0d data=%h err=%b other_err=%b expected own=%0d data=%h err=%b other_err=0",
                                 own, dat, er, other_er, e.own, e.data, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int  k;
        int  n;
        bit  exp_order [4];
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; ifu_req_v = 1'b1; ifu_adr = 32'h0;
        lsu_req_v = 1'b1; lsu_we = 1'b0; lsu_adr = 32'h0; lsu_data = 32'h0; lsu_strobe = 4'h0;
        mem_resp = 32'h0; mem_ack = 1'b0;
        step(); step();
        chk_zero("reset");
        ifu_req_v = 1'b0; lsu_req_v = 1'b0; rst_n = 1'b1;
        step();

        // Single IFU read, ack 2 cycles after mem_r_v
        ifu_read("ifu_read", 32'h100, 32'hDEADBEEF, 2, 1'b0);

        // LSU write, response two cycles after accept without ack
        lsu_req_v = 1'b1; lsu_we = 1'b1; lsu_adr = 32'h200; lsu_data = 32'h11223344;
        lsu_strobe = 4'b0011;
        #1;
        chk("wr_gnt", {30'h0, ifu_gnt, lsu_gnt}, 32'h1);
        sb_q.push_back('{1'b1, 32'h0, 1'b0});
        step();
        lsu_req_v = 1'b0;
        chk("wr_strobes", {30'h0, mem_r_v, mem_w_v}, 32'h1);
        chk("wr_adr", mem_adr, 32'h200);
        chk("wr_data", mem_data, 32'h11223344);
        chk("wr_be", {28'h0, mem_strobe}, 32'h3);
        step();
        chk("wr_resp", {29'h0, ifu_resp_v, lsu_resp_v, mem_w_v}, 32'h2);
        step();

        // Both held requesting from reset: LSU, IFU, LSU, IFU
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        auto_ack = 1'b1; auto_data = 32'hCAFE0001;
        ifu_req_v = 1'b1; ifu_adr = 32'h300;
        lsu_req_v = 1'b1; lsu_we = 1'b1; lsu_adr = 32'h400; lsu_data = 32'h55AA55AA;
        lsu_strobe = 4'hF;
        k = 0;
        for (int c = 0; c < 80 && k < 4; c++) begin
            #1;
            if (ifu_gnt || lsu_gnt) begin
                chk("rr_owner", {30'h0, ifu_gnt, lsu_gnt}, exp_order[k] ? 32'h1 : 32'h2);
                if (exp_order[k]) sb_q.push_back('{1'b1, 32'h0, 1'b0});
                else              sb_q.push_back('{1'b0, 32'hCAFE0001, 1'b0});
                k++;
            end
            step();
        end
        chk("rr_grants", k, 32'd4);
        ifu_req_v = 1'b0; lsu_req_v = 1'b0;
        for (int c = 0; c < 6; c++) step();
        auto_ack = 1'b0; mem_ack = 1'b0;
        step();

        // Reset during WAIT drops the transaction; later ack ignored
        ifu_req_v = 1'b1; ifu_adr = 32'h500;
        step();
        ifu_req_v = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk_zero("rst_wait");
        rst_n = 1'b1;
        step();
        mem_ack = 1'b1; mem_resp = 32'hBAD00001;
        step(); step(); step();
        chk("rst_stale_ack", {29'h0, ifu_resp_v, lsu_resp_v, mem_r_v}, 32'h0);
        mem_ack = 1'b0;
        step();
        ifu_read("post_rst", 32'h600, 32'h600D600D, 1, 1'b0);

        // Stale ack in ISSUE must not complete the read
        ifu_read("stale_issue", 32'h604, 32'h12345678, 2, 1'b1);

`ifdef MEM_ARB_TIMEOUT_EN
        ifu_req_v = 1'b1; ifu_adr = 32'h700;
        #1;
        sb_q.push_back('{1'b0, 32'h0, 1'b1});
        step();
        ifu_req_v = 1'b0;
        n = 0;
        while (!ifu_resp_v && n < 40) begin
            step();
            n++;
        end
        chk("to_latency", n, 32'd16);
        step();
        ifu_read("to_ack15", 32'h704, 32'h15151515, 15, 1'b0);
`else
        n = 0;
        ifu_read("no_timeout", 32'h708, 32'h20202020, 20, 1'b0);
`endif

        for (int c = 0; c < 4; c++) step();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
